// File: rtl/div_seq.sv
// Multi-cycle restoring shift-subtract divider for the Y86-64 execute stage.
// Signed or unsigned 64-bit operands; one quotient bit per clock, one-cycle done pulse.
module div_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] dvd_r;    // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] prem_r;
  logic [CW-1:0]    cnt_r;
  logic             qneg_r, rneg_r, dz_r, ovf_r;

  logic             accept, div_zero, last_iter, fits;
  logic [WIDTH-1:0] dividend_abs, divisor_abs, rem_sub;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] q_final, r_final;

  assign accept    = (state == IDLE) && start;
  assign div_zero  = (divisor == '0);
  assign last_iter = (cnt_r == CW'(WIDTH - 1));

  assign dividend_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_abs  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
  assign shifted = {prem_r, dvd_r[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs_r});
  assign rem_sub = shifted[WIDTH-1:0] - dvs_r;

  // State register
  // NOTE: every clocked process uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting first keeps this block combinational on every path (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = div_zero ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: sign-corrected results presented to the output registers in DONE
  always_comb begin
    q_final = qneg_r ? -dvd_r  : dvd_r;
    r_final = rneg_r ? -prem_r : prem_r;
  end

  // Datapath: operand capture and one restoring iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r  <= '0;
      dvs_r  <= '0;
      prem_r <= '0;
      cnt_r  <= '0;
      qneg_r <= 1'b0;
      rneg_r <= 1'b0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cnt_r <= '0;
          dz_r  <= div_zero;
          ovf_r <= sign && (dividend == MIN_NEG) && (&divisor);
          if (div_zero) begin
            // Divide-by-zero presets: all-ones quotient, dividend passed through untouched.
            dvd_r  <= '1;
            prem_r <= dividend;
            qneg_r <= 1'b0;
            rneg_r <= 1'b0;
          end else begin
            dvd_r  <= dividend_abs;
            dvs_r  <= divisor_abs;
            prem_r <= '0;
            qneg_r <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_r <= sign && dividend[WIDTH-1];
          end
        end
        CALC: begin
          dvd_r  <= {dvd_r[WIDTH-2:0], fits};
          prem_r <= fits ? rem_sub : shifted[WIDTH-1:0];
          cnt_r  <= cnt_r + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: held stable until the next DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (accept)
        busy <= 1'b1;
      else if (state == DONE)
        busy <= 1'b0;
      if (state == DONE) begin
        quotient  <= q_final;
        remainder <= r_final;
        dz        <= dz_r;
        ovf       <= ovf_r;
      end
    end
  end

endmodule
